// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between an instruction-fetch port and a data port.
// A single access runs IDLE -> BUSY (MEM_LATENCY cycles) -> DONE (one-cycle ready pulse).
//
// Parameters:
//   XLEN        address / fetch-data word width
//   MEM_LATENCY memory access cycles per transfer (1..15)
//
// Ports:
//   clk, rst_b            clock and synchronous active-high reset
//   halted                blocks new grants (in-flight access still completes)
//   i_req/i_addr          fetch request; i_ready pulse + i_rdata {lane3..lane0}
//   d_req/d_we/d_addr/d_wdata   data request; d_ready pulse + d_rdata
//   mem_addr/mem_data_in/mem_write_en/mem_data_out   shared memory side
//   busy                  access in progress
//
// Optional feature: define MEM_ARB_RR_EN to resolve simultaneous requests round-robin
// (first tie after reset goes to data). Default is fixed data-port priority.
module mem_port_arbiter #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned MEM_LATENCY = 4
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 halted,
  input  logic                 i_req,
  input  logic [XLEN-1:0]      i_addr,
  output logic                 i_ready,
  output logic [XLEN-1:0]      i_rdata,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [XLEN-1:0]      d_addr,
  input  logic [3:0][7:0]      d_wdata,
  output logic                 d_ready,
  output logic [3:0][7:0]      d_rdata,
  output logic [XLEN-1:0]      mem_addr,
  output logic [3:0][7:0]      mem_data_in,
  input  logic [3:0][7:0]      mem_data_out,
  output logic                 mem_write_en,
  output logic                 busy
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  localparam logic [3:0] LastCnt = 4'(MEM_LATENCY - 1);

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            we_q, we_d;
  logic [3:0][7:0] wdata_q, wdata_d;
  logic            gnt_data_q, gnt_data_d;
  logic [XLEN-1:0] i_rdata_q, i_rdata_d;
  logic [3:0][7:0] d_rdata_q, d_rdata_d;
  logic            grant_data;
  logic            last_cycle;

`ifdef MEM_ARB_RR_EN
  logic last_data_q, last_data_d;
`endif

  // Port selection for a new grant.
  always_comb begin
`ifdef MEM_ARB_RR_EN
    if (i_req && d_req) grant_data = ~last_data_q;
    else                grant_data = d_req;
`else
    grant_data = d_req;
`endif
  end

  assign last_cycle = (state_q == StBusy) && (cnt_q == LastCnt);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    gnt_data_d = gnt_data_q;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
`ifdef MEM_ARB_RR_EN
    last_data_d = last_data_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (!halted && (i_req || d_req)) begin
          state_d    = StBusy;
          cnt_d      = '0;
          gnt_data_d = grant_data;
          addr_d     = grant_data ? d_addr : i_addr;
          // Fetches are always reads and carry no write data.
          we_d       = grant_data & d_we;
          wdata_d    = grant_data ? d_wdata : '0;
`ifdef MEM_ARB_RR_EN
          last_data_d = grant_data;
`endif
        end
      end
      StBusy: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LastCnt) begin
          state_d = StDone;
          if (gnt_data_q) d_rdata_d = mem_data_out;
          else            i_rdata_d = XLEN'(mem_data_out);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      gnt_data_q <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
`ifdef MEM_ARB_RR_EN
      last_data_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      gnt_data_q <= gnt_data_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
`ifdef MEM_ARB_RR_EN
      last_data_q <= last_data_d;
`endif
    end
  end

  assign busy         = (state_q != StIdle);
  assign i_ready      = (state_q == StDone) && !gnt_data_q;
  assign d_ready      = (state_q == StDone) && gnt_data_q;
  assign i_rdata      = i_rdata_q;
  assign d_rdata      = d_rdata_q;
  assign mem_addr     = (state_q == StBusy) ? addr_q  : '0;
  assign mem_data_in  = (state_q == StBusy) ? wdata_q : '0;
  assign mem_write_en = last_cycle && we_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (MEM_LATENCY = 4). Expected completions are
// queued when a request is driven and popped when the matching ready pulse appears.
module tb_mem_port_arbiter;

  localparam int unsigned XLEN = 32;
  localparam int unsigned LAT  = 4;

  logic            clk = 1'b0;
  logic            rst_b;
  logic            halted;
  logic            i_req;
  logic [31:0]     i_addr;
  logic            i_ready;
  logic [31:0]     i_rdata;
  logic            d_req;
  logic            d_we;
  logic [31:0]     d_addr;
  logic [3:0][7:0] d_wdata;
  logic            d_ready;
  logic [3:0][7:0] d_rdata;
  logic [31:0]     mem_addr;
  logic [3:0][7:0] mem_data_in;
  logic [3:0][7:0] mem_data_out;
  logic            mem_write_en;
  logic            busy;

  typedef struct packed {
    logic        is_data;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  mem_port_arbiter #(.XLEN(XLEN), .MEM_LATENCY(LAT)) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .halted       (halted),
    .i_req        (i_req),
    .i_addr       (i_addr),
    .i_ready      (i_ready),
    .i_rdata      (i_rdata),
    .d_req        (d_req),
    .d_we         (d_we),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_ready      (d_ready),
    .d_rdata      (d_rdata),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out),
    .mem_write_en (mem_write_en),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    rst_b = 1'b1; halted = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_data_out = '0;
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (busy !== 1'b0 || i_ready !== 1'b0 || d_ready !== 1'b0)
      $display("FAIL reset_ctrl busy/i_ready/d_ready=%b%b%b required 000", busy, i_ready, d_ready);
    else n_pass++;
    n_checks++;
    if (mem_addr !== 32'h0 || mem_data_in !== 32'h0 || mem_write_en !== 1'b0)
      $display("FAIL reset_mem addr=%h wdata=%h we=%b required 0/0/0",
               mem_addr, mem_data_in, mem_write_en);
    else n_pass++;
    n_checks++;
    if (i_rdata !== 32'h0 || d_rdata !== 32'h0)
      $display("FAIL reset_rdata i=%h d=%h required 0/0", i_rdata, d_rdata);
    else n_pass++;
  endtask

  task automatic test_fetch();
    bit   got = 0;
    bit   we_seen = 0;
    exp_t e;
    mem_data_out = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
    i_addr = 32'h100;
    i_req  = 1'b1;
    sb.push_back('{is_data: 1'b0, rdata: 32'hDEADBEEF});
    for (int k = 1; k <= 12 && !got; k++) begin
      @(negedge clk);
      if (mem_write_en) we_seen = 1;
      if (k == 1) begin
        n_checks++;
        if (busy !== 1'b1 || mem_addr !== 32'h100)
          $display("FAIL fetch_busy busy=%b addr=%h required 1/00000100", busy, mem_addr);
        else n_pass++;
      end
      if (i_ready || d_ready) begin
        got = 1;
        i_req = 1'b0;
        e = sb.pop_front();
        n_checks++;
        if (k !== LAT + 1 || d_ready !== 1'b0)
          $display("FAIL fetch_latency cycle=%0d d_ready=%b required %0d/0", k, d_ready, LAT + 1);
        else n_pass++;
        n_checks++;
        if (i_rdata !== e.rdata)
          $display("FAIL fetch_rdata got=%h required %h", i_rdata, e.rdata);
        else n_pass++;
      end
    end
    if (!got) begin
      n_checks++;
      $display("FAIL fetch_timeout no ready seen required i_ready within 12 cycles");
      void'(sb.pop_front());
    end
    n_checks++;
    if (we_seen !== 1'b0) $display("FAIL fetch_no_write mem_write_en seen=1 required 0");
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_write();
    bit   got = 0;
    exp_t e;
    mem_data_out = 32'h5A5A_5A5A;
    d_addr  = 32'h40;
    d_wdata[0] = 8'h11; d_wdata[1] = 8'h22; d_wdata[2] = 8'h33; d_wdata[3] = 8'h44;
    d_we    = 1'b1;
    d_req   = 1'b1;
    sb.push_back('{is_data: 1'b1, rdata: 32'h5A5A_5A5A});
    for (int k = 1; k <= 12 && !got; k++) begin
      @(negedge clk);
      if (k <= LAT) begin
        n_checks++;
        if (mem_addr !== 32'h40 || mem_write_en !== (k == LAT))
          $display("FAIL write_cycle%0d addr=%h we=%b required 00000040/%b",
                   k, mem_addr, mem_write_en, k == LAT);
        else n_pass++;
      end
      if (k == 1) begin
        n_checks++;
        if (mem_data_in !== 32'h4433_2211)
          $display("FAIL write_data got=%h required 44332211", mem_data_in);
        else n_pass++;
      end
      if (k > LAT && mem_write_en) begin
        n_checks++;
        $display("FAIL write_extra_we cycle=%0d we=1 required 0", k);
      end
      if (i_ready || d_ready) begin
        got = 1;
        d_req = 1'b0; d_we = 1'b0;
        e = sb.pop_front();
        n_checks++;
        if (k !== LAT + 1 || d_ready !== 1'b1)
          $display("FAIL write_ready cycle=%0d d_ready=%b required %0d/1", k, d_ready, LAT + 1);
        else n_pass++;
        n_checks++;
        if (d_rdata !== e.rdata) $display("FAIL write_rdata got=%h required %h", d_rdata, e.rdata);
        else n_pass++;
      end
    end
    if (!got) begin
      n_checks++;
      $display("FAIL write_timeout no ready seen required d_ready within 12 cycles");
      void'(sb.pop_front());
    end
    n_checks++;
    if (i_rdata !== 32'hDEADBEEF) $display("FAIL fetch_hold got=%h required deadbeef", i_rdata);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_tie();
    int   seen = 0;
    exp_t e;
    apply_reset();
    mem_data_out = 32'hCAFE_F00D;
    i_addr = 32'h300;
    d_addr = 32'h304;
    d_we   = 1'b0;
    i_req  = 1'b1;
    d_req  = 1'b1;
    sb.push_back('{is_data: 1'b1, rdata: 32'hCAFE_F00D});
    sb.push_back('{is_data: 1'b0, rdata: 32'hCAFE_F00D});
    for (int k = 1; k <= 30 && seen < 2; k++) begin
      @(negedge clk);
      if (k == 1) begin
        n_checks++;
        if (mem_addr !== 32'h304) $display("FAIL tie_first_addr got=%h required 00000304", mem_addr);
        else n_pass++;
      end
      if (i_ready || d_ready) begin
        seen++;
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL tie_unexpected_ready i=%b d=%b required none", i_ready, d_ready);
        end else begin
          e = sb.pop_front();
          n_checks++;
          if (d_ready !== e.is_data || i_ready !== !e.is_data)
            $display("FAIL tie_order%0d i=%b d=%b required d_ready=%b", seen, i_ready, d_ready,
                     e.is_data);
          else n_pass++;
          n_checks++;
          if ((e.is_data ? d_rdata : i_rdata) !== e.rdata)
            $display("FAIL tie_rdata%0d got=%h required %h", seen,
                     e.is_data ? d_rdata : i_rdata, e.rdata);
          else n_pass++;
        end
        if (d_ready) begin
`ifndef MEM_ARB_RR_EN
          d_req = 1'b0;  // fixed priority: data requester is done, fetch follows
`endif
        end
        if (seen == 2) begin
          i_req = 1'b0; d_req = 1'b0;
        end
      end
    end
    if (seen < 2) begin
      n_checks++;
      $display("FAIL tie_timeout ready_count=%0d required 2", seen);
      i_req = 1'b0; d_req = 1'b0;
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_halted();
    bit   bad = 0;
    bit   got = 0;
    exp_t e;
    halted = 1'b1;
    i_addr = 32'h200;
    i_req  = 1'b1;
    mem_data_out = 32'h0123_4567;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (busy || i_ready || d_ready) bad = 1;
    end
    n_checks++;
    if (bad !== 1'b0) $display("FAIL halted_no_grant grant seen=1 required 0");
    else n_pass++;
    halted = 1'b0;
    sb.push_back('{is_data: 1'b0, rdata: 32'h0123_4567});
    for (int k = 1; k <= 12 && !got; k++) begin
      @(negedge clk);
      if (k == 2) halted = 1'b1;
      if (i_ready || d_ready) begin
        got = 1;
        i_req = 1'b0;
        e = sb.pop_front();
        n_checks++;
        if (k !== LAT + 1 || i_ready !== 1'b1)
          $display("FAIL halted_mid_ready cycle=%0d i_ready=%b required %0d/1", k, i_ready, LAT + 1);
        else n_pass++;
        n_checks++;
        if (i_rdata !== e.rdata) $display("FAIL halted_mid_rdata got=%h required %h", i_rdata, e.rdata);
        else n_pass++;
      end
    end
    if (!got) begin
      n_checks++;
      $display("FAIL halted_mid_timeout no ready required i_ready within 12 cycles");
      void'(sb.pop_front());
    end
    halted = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit bad = 0;
    d_addr = 32'h80;
    d_wdata = 32'hA1B2_C3D4;
    d_we  = 1'b1;
    d_req = 1'b1;
    @(negedge clk);  // first BUSY cycle
    @(negedge clk);  // second BUSY cycle
    n_checks++;
    if (busy !== 1'b1) $display("FAIL rstmid_busy busy=%b required 1", busy);
    else n_pass++;
    rst_b = 1'b1;
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    rst_b = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || mem_write_en !== 1'b0)
      $display("FAIL rstmid_abort busy=%b we=%b required 0/0", busy, mem_write_en);
    else n_pass++;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (mem_write_en || d_ready || i_ready || busy) bad = 1;
    end
    n_checks++;
    if (bad !== 1'b0) $display("FAIL rstmid_quiet activity seen=1 required 0");
    else n_pass++;
    n_checks++;
    if (i_rdata !== 32'h0 || d_rdata !== 32'h0)
      $display("FAIL rstmid_rdata i=%h d=%h required 0/0", i_rdata, d_rdata);
    else n_pass++;
  endtask

  initial begin
    rst_b = 1'b1; halted = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_data_out = '0;
    test_reset();
    test_fetch();
    test_write();
    test_tie();
    test_halted();
    test_reset_mid();
    n_checks++;
    if (sb.size() !== 0) $display("FAIL scoreboard_drain left=%0d required 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
